// File: rtl/pkt_fifo_ctrl_if.sv
// Write, read and status bundle of the packet FIFO.
// master = producer/consumer side, slave = the FIFO itself.
interface pkt_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int AW         = 10,
  parameter int CNT_WIDTH  = 16
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  sof_in;
  logic                  eof_in;
  logic                  wr_abort;
  logic                  full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  sof_out;
  logic                  eof_out;
  logic                  empty;
  logic [AW:0]           frame_count;
  logic                  drop_pulse;
  logic [CNT_WIDTH-1:0]  drop_count;

  modport master (
    output wr_en, din, sof_in, eof_in, wr_abort, rd_en,
    input  full, dout, sof_out, eof_out, empty, frame_count, drop_pulse, drop_count
  );

  modport slave (
    input  wr_en, din, sof_in, eof_in, wr_abort, rd_en,
    output full, dout, sof_out, eof_out, empty, frame_count, drop_pulse, drop_count
  );
endinterface

// File: rtl/pkt_fifo_ctrl.sv
// Store-and-forward packet FIFO: frames are written speculatively and only become
// readable once their eof beat commits; aborted, malformed or oversized frames are rewound.
module pkt_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input  logic           clk,
  input  logic           reset,
  pkt_fifo_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int MW = DATA_WIDTH + 2;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, IN_FRAME, DROP} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [AW:0]          r_wr_ptr;
  logic [AW:0]          r_cm_ptr;
  logic [AW:0]          r_rd_ptr;
  logic [AW:0]          w_wr_ptr_next;
  logic [AW:0]          w_cm_ptr_next;
  logic [AW-1:0]        w_wr_addr;
  logic                 w_we;
  logic                 w_commit;
  logic                 w_drop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_rd_fire;
  logic                 w_rd_eof;
  logic [MW-1:0]        r_mem [DEPTH];
  logic [DEPTH-1:0]     r_eof_flag;
  logic [MW-1:0]        r_rd_word;
  logic [AW:0]          r_frame_count;
  logic                 r_drop_pulse;
  logic [CNT_WIDTH-1:0] r_drop_count;

  assign w_full    = (r_wr_ptr - r_rd_ptr) == DEPTH_L;
  assign w_empty   = (r_rd_ptr == r_cm_ptr);
  assign w_rd_fire = bus.rd_en && !w_empty;
  // eof flags are kept beside the RAM so frame_count can drop on the read edge itself
  assign w_rd_eof  = r_eof_flag[r_rd_ptr[AW-1:0]];

  always_comb begin
    w_state_next  = r_state;
    w_wr_ptr_next = r_wr_ptr;
    w_cm_ptr_next = r_cm_ptr;
    w_wr_addr     = r_wr_ptr[AW-1:0];
    w_we          = 1'b0;
    w_commit      = 1'b0;
    w_drop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.wr_en) begin
          if (w_full || !bus.sof_in) begin
            w_drop       = 1'b1;
            w_state_next = bus.eof_in ? IDLE : DROP;
          end else begin
            w_we          = 1'b1;
            w_wr_ptr_next = r_wr_ptr + 1'b1;
            if (bus.eof_in) begin
              w_commit      = 1'b1;
              w_cm_ptr_next = r_wr_ptr + 1'b1;
            end else begin
              w_state_next = IN_FRAME;
            end
          end
        end
      end
      IN_FRAME: begin
        if (bus.wr_abort) begin
          w_drop        = 1'b1;
          w_wr_ptr_next = r_cm_ptr;
          w_state_next  = IDLE;
        end else if (bus.wr_en) begin
          if (w_full) begin
            w_drop        = 1'b1;
            w_wr_ptr_next = r_cm_ptr;
            w_state_next  = bus.eof_in ? IDLE : DROP;
          end else if (bus.sof_in) begin
            // unterminated frame is abandoned; the new sof beat restarts at the commit point
            w_drop        = 1'b1;
            w_we          = 1'b1;
            w_wr_addr     = r_cm_ptr[AW-1:0];
            w_wr_ptr_next = r_cm_ptr + 1'b1;
            if (bus.eof_in) begin
              w_commit      = 1'b1;
              w_cm_ptr_next = r_cm_ptr + 1'b1;
              w_state_next  = IDLE;
            end
          end else begin
            w_we          = 1'b1;
            w_wr_ptr_next = r_wr_ptr + 1'b1;
            if (bus.eof_in) begin
              w_commit      = 1'b1;
              w_cm_ptr_next = r_wr_ptr + 1'b1;
              w_state_next  = IDLE;
            end
          end
        end
      end
      DROP: begin
        // the frame being skipped was already counted when DROP was entered
        if (bus.wr_en && bus.eof_in) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_wr_addr]      <= {bus.sof_in, bus.eof_in, bus.din};
      r_eof_flag[w_wr_addr] <= bus.eof_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_wr_ptr      <= '0;
      r_cm_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_rd_word     <= '0;
      r_frame_count <= '0;
      r_drop_pulse  <= 1'b0;
      r_drop_count  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_wr_ptr     <= w_wr_ptr_next;
      r_cm_ptr     <= w_cm_ptr_next;
      r_drop_pulse <= w_drop;
      if (w_rd_fire) begin
        r_rd_word <= r_mem[r_rd_ptr[AW-1:0]];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
      case ({w_commit, w_rd_fire && w_rd_eof})
        2'b10:   r_frame_count <= r_frame_count + 1'b1;
        2'b01:   r_frame_count <= r_frame_count - 1'b1;
        default: r_frame_count <= r_frame_count;
      endcase
      if (w_drop && (r_drop_count != {CNT_WIDTH{1'b1}})) begin
        r_drop_count <= r_drop_count + 1'b1;
      end
    end
  end

  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.dout        = r_rd_word[DATA_WIDTH-1:0];
  assign bus.sof_out     = r_rd_word[MW-1];
  assign bus.eof_out     = r_rd_word[MW-2];
  assign bus.frame_count = r_frame_count;
  assign bus.drop_pulse  = r_drop_pulse;
  assign bus.drop_count  = r_drop_count;
endmodule

// File: tb/tb_pkt_fifo_ctrl.sv
// Bench for pkt_fifo_ctrl (DEPTH = 8): status vector table plus corner-case sequences;
// read beats are checked against a queue filled as surviving beats are driven.
module tb_pkt_fifo_ctrl;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int CW    = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pkt_fifo_ctrl_if #(.DATA_WIDTH(DW), .AW(AW), .CNT_WIDTH(CW)) bus ();

  pkt_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       wr, sof, eof, ab, rd;
    logic [7:0] din;
    logic       keep;
    logic       e_empty, e_full;
    int         e_fc, e_dc;
  } vec_t;

  vec_t        vecs[$];
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] exp_w;
  logic        rd_pending = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_reads = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(logic wr, logic sof, logic eof, logic ab, logic rd,
                              logic [7:0] din, logic keep, logic e_empty, logic e_full,
                              int e_fc, int e_dc);
    vec_t v;
    v.wr = wr; v.sof = sof; v.eof = eof; v.ab = ab; v.rd = rd;
    v.din = din; v.keep = keep; v.e_empty = e_empty; v.e_full = e_full;
    v.e_fc = e_fc; v.e_dc = e_dc;
    vecs.push_back(v);
  endfunction

  task automatic drive(logic wr, logic sof, logic eof, logic ab, logic rd,
                       logic [7:0] d, logic keep);
    bus.wr_en    = wr;
    bus.sof_in   = sof;
    bus.eof_in   = eof;
    bus.wr_abort = ab;
    bus.rd_en    = rd;
    bus.din      = d;
    if (wr && keep) exp_q.push_back({sof, eof, d});
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
  endtask

  // one read request accepted before an edge lands on dout after that edge
  always @(negedge clk) begin
    if (!reset) begin
      rd_pending = 1'b0;
    end else begin
      if (rd_pending) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL read_beat: got 0x%0h, expected no beat",
                   {bus.sof_out, bus.eof_out, bus.dout});
        end else begin
          exp_w = exp_q.pop_front();
          check("read_beat", {bus.sof_out, bus.eof_out, bus.dout}, exp_w);
          n_reads++;
        end
      end
      rd_pending = bus.rd_en && !bus.empty;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int reads_before;

    // 4-beat frame, read back
    add(1,1,0,0,0,8'hA0,1, 1,0,0,0);
    add(1,0,0,0,0,8'hA1,1, 1,0,0,0);
    add(1,0,0,0,0,8'hA2,1, 1,0,0,0);
    add(1,0,1,0,0,8'hA3,1, 0,0,1,0);
    add(0,0,0,0,1,8'h00,0, 0,0,1,0);
    add(0,0,0,0,1,8'h00,0, 0,0,1,0);
    add(0,0,0,0,1,8'h00,0, 0,0,1,0);
    add(0,0,0,0,1,8'h00,0, 1,0,0,0);
    add(0,0,0,0,1,8'h00,0, 1,0,0,0);
    // abort after 3 beats, then a clean 2-beat frame
    add(1,1,0,0,0,8'hB0,0, 1,0,0,0);
    add(1,0,0,0,0,8'hB1,0, 1,0,0,0);
    add(1,0,0,0,0,8'hB2,0, 1,0,0,0);
    add(0,0,0,1,0,8'h00,0, 1,0,0,1);
    add(1,1,0,0,0,8'hC0,1, 1,0,0,1);
    add(1,0,1,0,0,8'hC1,1, 0,0,1,1);
    add(0,0,0,0,1,8'h00,0, 0,0,1,1);
    add(0,0,0,0,1,8'h00,0, 1,0,0,1);
    add(0,0,0,1,0,8'h00,0, 1,0,0,1);
    // beat without sof in IDLE, sof beat while dropping, then a 1-beat frame
    add(1,0,0,0,0,8'h55,0, 1,0,0,2);
    add(1,1,1,0,0,8'h56,0, 1,0,0,2);
    add(1,1,1,0,0,8'h77,1, 0,0,1,2);
    add(0,0,0,0,1,8'h00,0, 1,0,0,2);
    // commit and eof read in the same cycle
    add(1,1,1,0,0,8'h78,1, 0,0,1,2);
    add(1,1,1,0,1,8'h79,1, 0,0,1,2);
    add(0,0,0,0,1,8'h00,0, 1,0,0,2);
    // fill to full, overflow frame dropped, drain
    for (int k = 0; k < DEPTH; k++)
      add(1,1,1,0,0,8'h80+8'(k),1, 0,(k == DEPTH-1),k+1,2);
    add(1,1,1,0,0,8'h90,0, 0,1,DEPTH,3);
    for (int k = 0; k < DEPTH; k++)
      add(0,0,0,0,1,8'h00,0, (k == DEPTH-1),0,DEPTH-1-k,3);

    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_fc", bus.frame_count, 0);
    check("rst_dc", bus.drop_count, 0);
    check("rst_dout", {bus.sof_out, bus.eof_out, bus.dout}, 0);
    check("rst_pulse", bus.drop_pulse, 0);
    reset = 1'b1;
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].wr, vecs[i].sof, vecs[i].eof, vecs[i].ab, vecs[i].rd,
            vecs[i].din, vecs[i].keep);
      tick();
      check($sformatf("v%0d_empty", i), bus.empty, vecs[i].e_empty);
      check($sformatf("v%0d_full", i), bus.full, vecs[i].e_full);
      check($sformatf("v%0d_fc", i), bus.frame_count, vecs[i].e_fc);
      check($sformatf("v%0d_dc", i), bus.drop_count, vecs[i].e_dc);
    end
    idle();
    tick();
    check("table_drained", exp_q.size(), 0);

    // oversized 10-beat frame
    do_reset();
    for (int b = 0; b < 10; b++) begin
      drive(1'b1, b == 0, b == 9, 1'b0, 1'b0, 8'h10 + 8'(b), 1'b0);
      tick();
      if (b == 7) check("ovf_full_after8", bus.full, 1);
      check($sformatf("ovf_pulse_b%0d", b + 1), bus.drop_pulse, (b == 8));
    end
    idle();
    tick();
    check("ovf_empty", bus.empty, 1);
    check("ovf_dc", bus.drop_count, 1);
    check("ovf_fc", bus.frame_count, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1);
    tick();
    check("ovf_idle_after_eof", bus.empty, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    tick();
    idle();
    tick();

    // unterminated frame B replaced by C
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hB0, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hB1, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC0, 1'b1); tick();
    check("bc_pulse", bus.drop_pulse, 1);
    check("bc_dc", bus.drop_count, 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC1, 1'b1); tick();
    check("bc_pulse_clr", bus.drop_pulse, 0);
    check("bc_not_ready", bus.empty, 1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC2, 1'b1); tick();
    check("bc_fc", bus.frame_count, 1);
    check("bc_ready", bus.empty, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    repeat (3) tick();
    idle();
    tick();
    check("bc_fc_end", bus.frame_count, 0);
    check("bc_empty_end", bus.empty, 1);

    // streaming 1-beat frames across pointer wrap with rd_en held high
    do_reset();
    reads_before = n_reads;
    for (int k = 0; k < 3 * DEPTH; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hE0 + 8'(k), 1'b1);
      tick();
      check($sformatf("wrap_fc_le_depth_%0d", k), bus.frame_count <= DEPTH, 1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    for (int c = 0; c < 20 && !(bus.empty && exp_q.size() == 0); c++) tick();
    idle();
    tick();
    check("wrap_drained", exp_q.size(), 0);
    check("wrap_reads", n_reads - reads_before, 3 * DEPTH);
    check("wrap_fc", bus.frame_count, 0);

    // async reset in the middle of a frame with two committed frames pending
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h20, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h21, 1'b1); tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h23, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h24, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h25, 1'b0); tick();
    check("mid_fc", bus.frame_count, 2);
    check("mid_dc", bus.drop_count, 1);
    idle();
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_dout", {bus.sof_out, bus.eof_out, bus.dout}, 0);
    check("mid_rst_empty", bus.empty, 1);
    check("mid_rst_full", bus.full, 0);
    check("mid_rst_fc", bus.frame_count, 0);
    check("mid_rst_dc", bus.drop_count, 0);
    check("mid_rst_pulse", bus.drop_pulse, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h61, 1'b1); tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h62, 1'b1); tick();
    check("post_rst_fc", bus.frame_count, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    repeat (2) tick();
    idle();
    tick();
    check("post_rst_empty", bus.empty, 1);
    check("final_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
